ball_bounce_ctrl: RTL and testbench

Velocity controller for the ball: it is the consumer of the ball position produced by the ball dynamics block, and it returns the velocity that block adds. It paces motion with a step strobe, checks the predicted next position against the playfield walls, and reflects the velocity component on contact. It optionally counts bounces for the scoring logic.

---
 rtl/ball_pkg.sv | 23 ++
 rtl/ball_tick_div.sv | 29 ++
 rtl/ball_bounce_ctrl.sv | 142 ++++++++++++++
 tb/tb_ball_bounce_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared ball definitions: position/velocity width, velocity type, FSM states, wall limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The wall limits are the same defaults the dynamics block uses.
package ball_pkg;

    localparam int BALL_W = 4;

    // Two's complement velocity, added to the position on each step.
    typedef logic signed [BALL_W-1:0] vel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam int X_MIN_DEF = 0;
    localparam int X_MAX_DEF = 15;
    localparam int Y_MIN_DEF = 0;
    localparam int Y_MAX_DEF = 15;

endpackage

// File: rtl/ball_tick_div.sv
// Step pacing divider: modulo-TICK_DIV counter that advances only while run=1.
// Latency: tc is combinational on the terminal count of the current cycle.
// Backpressure: run=0 holds the count, and tc stays low.
// Ports: clk_50, reset_n (async, active-low), run (count enable), tc (terminal-count strobe).
module ball_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk_50,
    input  logic reset_n,
    input  logic run,
    output logic tc
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tc = run && (count == LAST);

endmodule

// File: rtl/ball_bounce_ctrl.sv
// Ball velocity controller: launches at +SPEED, paces steps, reflects velocity at walls.
// Latency: step strobes on the last RUN count; the reflection and bounce pulses register at the end of CHECK.
// Backpressure: enable=0 freezes the divider, FSM and registers, and suppresses step and new bounce pulses.
// Ports: clk_50, reset_n (async, active-low), enable, ball_position_x/y (unsigned, in),
//        ball_velocity_x/y (signed, out), step, bounce_x, bounce_y, bounce_count.
// Build option: define BALL_BOUNCE_COUNT_EN to implement the saturating bounce_count.
//               Without it, bounce_count is tied to 0.
module ball_bounce_ctrl
    import ball_pkg::*;
#(
    parameter int W        = BALL_W,
    parameter int X_MIN    = X_MIN_DEF,
    parameter int X_MAX    = X_MAX_DEF,
    parameter int Y_MIN    = Y_MIN_DEF,
    parameter int Y_MAX    = Y_MAX_DEF,
    parameter int SPEED    = 1,
    parameter int TICK_DIV = 4
) (
    input  logic         clk_50,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [W-1:0] ball_position_x,
    input  logic [W-1:0] ball_position_y,
    output logic [W-1:0] ball_velocity_x,
    output logic [W-1:0] ball_velocity_y,
    output logic         step,
    output logic         bounce_x,
    output logic         bounce_y,
    output logic [7:0]   bounce_count
);

    localparam int SW = W + 2;
    localparam logic [W-1:0] SPEED_V = W'(SPEED);

    state_t state;
    state_t state_nxt;
    logic   run;
    logic   tc;
    logic   load_launch;
    logic   do_check;
    logic   flip_x;
    logic   flip_y;

    // Two extra bits keep p + v free of overflow, even for positions beyond the walls.
    function automatic logic hits_wall(input logic [W-1:0] p, input logic [W-1:0] v,
                                       input int lo, input int hi);
        logic signed [SW-1:0] sum;
        logic                 v_pos;
        logic                 v_neg;
        sum   = $signed({2'b00, p}) + $signed({{2{v[W-1]}}, v});
        v_neg = v[W-1];
        v_pos = !v[W-1] && (v != '0);
        return (v_pos && (sum > $signed(SW'(hi)))) || (v_neg && (sum < $signed(SW'(lo))));
    endfunction

    ball_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .run     (run),
        .tc      (tc)
    );

    // State register.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. The whole FSM holds while enable is low.
    always_comb begin
        state_nxt = state;
        if (enable) begin
            case (state)
                IDLE:    state_nxt = LAUNCH;
                LAUNCH:  state_nxt = RUN;
                RUN:     state_nxt = tc ? CHECK : RUN;
                CHECK:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        run         = enable && (state == RUN);
        load_launch = enable && (state == LAUNCH);
        do_check    = enable && (state == CHECK);
    end

    // step is the divider's terminal count. The dynamics block adds the velocity on the same edge
    // that moves this FSM into CHECK, so CHECK sees the already-stepped position.
    assign step = tc;

    always_comb begin
        flip_x = do_check && hits_wall(ball_position_x, ball_velocity_x, X_MIN, X_MAX);
        flip_y = do_check && hits_wall(ball_position_y, ball_velocity_y, Y_MIN, Y_MAX);
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            ball_velocity_x <= '0;
            ball_velocity_y <= '0;
            bounce_x        <= 1'b0;
            bounce_y        <= 1'b0;
        end else begin
            bounce_x <= flip_x;
            bounce_y <= flip_y;
            if (load_launch) begin
                ball_velocity_x <= SPEED_V;
                ball_velocity_y <= SPEED_V;
            end else begin
                if (flip_x) ball_velocity_x <= -ball_velocity_x;
                if (flip_y) ball_velocity_y <= -ball_velocity_y;
            end
        end
    end

`ifdef BALL_BOUNCE_COUNT_EN
    // A corner adds two. The ninth bit catches the step past 255 so the count clamps instead of wrapping.
    logic [8:0] count_sum;

    always_comb begin
        count_sum = {1'b0, bounce_count} + 9'(flip_x) + 9'(flip_y);
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            bounce_count <= '0;
        end else begin
            bounce_count <= count_sum[8] ? 8'hFF : count_sum[7:0];
        end
    end
`else
    assign bounce_count = '0;
`endif

endmodule

// File: tb/tb_ball_bounce_ctrl.sv
module tb_ball_bounce_ctrl;

    localparam int W        = 4;
    localparam int X_MIN    = 0;
    localparam int X_MAX    = 15;
    localparam int Y_MIN    = 0;
    localparam int Y_MAX    = 15;
    localparam int SPEED    = 1;
    localparam int TICK_DIV = 4;
    localparam int PERIOD   = TICK_DIV + 1;

    logic         clk_50 = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [W-1:0] ball_position_x;
    logic [W-1:0] ball_position_y;
    logic [W-1:0] ball_velocity_x;
    logic [W-1:0] ball_velocity_y;
    logic         step;
    logic         bounce_x;
    logic         bounce_y;
    logic [7:0]   bounce_count;

    ball_bounce_ctrl #(
        .W        (W),
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX),
        .Y_MIN    (Y_MIN),
        .Y_MAX    (Y_MAX),
        .SPEED    (SPEED),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk_50          (clk_50),
        .reset_n         (reset_n),
        .enable          (enable),
        .ball_position_x (ball_position_x),
        .ball_position_y (ball_position_y),
        .ball_velocity_x (ball_velocity_x),
        .ball_velocity_y (ball_velocity_y),
        .step            (step),
        .bounce_x        (bounce_x),
        .bounce_y        (bounce_y),
        .bounce_count    (bounce_count)
    );

    always #10 clk_50 = ~clk_50;

    int checks   = 0;
    int failures = 0;

    // Reference model. n counts enabled cycles since reset release: cycle 0 is idle, cycle 1 is launch,
    // and from cycle 2 each motion period has TICK_DIV run cycles followed by one check cycle.
    int n;
    int mvx, mvy;
    int mbx, mby;
    int mcnt;
    int contacts;
    int chk_idx;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t n=%0d)", tag, got, exp, $time, n);
        end
    endtask

    function automatic int exp_count(input int c);
`ifdef BALL_BOUNCE_COUNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic model_reset();
        n = 0; mvx = 0; mvy = 0; mbx = 0; mby = 0; mcnt = 0; chk_idx = 0;
    endtask

    // Called just after a falling edge. Applies inputs, checks the outputs of this cycle,
    // then advances the model to the next rising edge.
    task automatic run_cycle(input logic en, input int px, input int py);
        logic [W-1:0] evx;
        logic [W-1:0] evy;
        bit           stp;
        bit           chk;
        int           nbx;
        int           nby;
        enable          = en;
        ball_position_x = px[W-1:0];
        ball_position_y = py[W-1:0];
        #1;
        evx = mvx[W-1:0];
        evy = mvy[W-1:0];
        stp = en && (n >= 2) && (((n - 2) % PERIOD) == TICK_DIV - 1);
        chk = (n >= 2) && (((n - 2) % PERIOD) == TICK_DIV);
        check_val("vel_x", ball_velocity_x, evx);
        check_val("vel_y", ball_velocity_y, evy);
        check_val("step", step, stp);
        check_val("bounce_x", bounce_x, mbx);
        check_val("bounce_y", bounce_y, mby);
        check_val("bounce_count", bounce_count, exp_count(mcnt));
        nbx = 0;
        nby = 0;
        if (en) begin
            if (n == 1) begin
                mvx = SPEED;
                mvy = SPEED;
            end else if (chk) begin
                if ((mvx > 0 && px + mvx > X_MAX) || (mvx < 0 && px + mvx < X_MIN)) begin
                    mvx = -mvx; nbx = 1;
                end
                if ((mvy > 0 && py + mvy > Y_MAX) || (mvy < 0 && py + mvy < Y_MIN)) begin
                    mvy = -mvy; nby = 1;
                end
                contacts += nbx + nby;
                mcnt = (mcnt + nbx + nby > 255) ? 255 : mcnt + nbx + nby;
                chk_idx++;
            end
            n++;
        end
        mbx = nbx;
        mby = nby;
        @(negedge clk_50);
    endtask

    function automatic int dir_x(input int idx);
        case (idx)
            0:       return 15;
            1:       return 7;
            2:       return 0;
            default: return 7;
        endcase
    endfunction

    function automatic int dir_y(input int idx);
        case (idx)
            0:       return 7;
            1:       return 15;
            2:       return 0;
            default: return 7;
        endcase
    endfunction

    function automatic int wall_or_rand(input int v, input int lo, input int hi);
        if ($urandom_range(0, 1) == 1) return (v > 0) ? hi : lo;
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        bit froze;
        bit found;
        int px;
        int py;
        reset_n = 1'b0;
        enable = 1'b0;
        ball_position_x = '0;
        ball_position_y = '0;
        contacts = 0;
        model_reset();

        // Outputs must be zero while reset is held.
        repeat (3) @(negedge clk_50);
        check_val("rst_vel_x", ball_velocity_x, 0);
        check_val("rst_vel_y", ball_velocity_y, 0);
        check_val("rst_step", step, 0);
        check_val("rst_bounce_x", bounce_x, 0);
        check_val("rst_bounce_y", bounce_y, 0);
        check_val("rst_count", bounce_count, 0);
        reset_n = 1'b1;

        // Launch, right wall, top wall, corner, then a 10-cycle freeze mid-count.
        froze = 0;
        while (n < 32) begin
            if (n == 7) begin
                check_val("rwall_vx", ball_velocity_x, 4'hF);
                check_val("rwall_vy", ball_velocity_y, 4'h1);
                check_val("rwall_bx", bounce_x, 1);
                check_val("rwall_by", bounce_y, 0);
            end
            if (n == 17) begin
                check_val("corner_vx", ball_velocity_x, 4'h1);
                check_val("corner_vy", ball_velocity_y, 4'h1);
                check_val("corner_bx", bounce_x, 1);
                check_val("corner_by", bounce_y, 1);
            end
            if (chk_idx == 3 && !froze && (n - 2) % PERIOD == 1) begin
                repeat (10) run_cycle(1'b0, 7, 7);
                froze = 1;
            end else begin
                run_cycle(1'b1, dir_x(chk_idx), dir_y(chk_idx));
            end
        end
        check_val("dir_count", bounce_count, exp_count(4));

        // Random segment: positions biased toward the wall the ball is heading for.
        for (int k = 0; k < 8000 && contacts < 300; k++) begin
            px = wall_or_rand(mvx, X_MIN, X_MAX);
            py = wall_or_rand(mvy, Y_MIN, Y_MAX);
            run_cycle(($urandom_range(0, 9) != 0), px, py);
        end
        check_val("contacts_reached", contacts >= 300, 1);
        repeat (10) run_cycle(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        check_val("sat_count", bounce_count, exp_count(255));

        // Reset asserted in the middle of a bouncing check cycle.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (n >= 2 && (n - 2) % PERIOD == TICK_DIV) begin
                found = 1;
            end else begin
                run_cycle(1'b1, 7, 7);
            end
        end
        check_val("check_found", found, 1);
        enable = 1'b1;
        ball_position_x = (mvx > 0) ? 4'd15 : 4'd0;
        ball_position_y = 4'd7;
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_vel_x", ball_velocity_x, 0);
        check_val("arst_vel_y", ball_velocity_y, 0);
        check_val("arst_step", step, 0);
        check_val("arst_count", bounce_count, 0);
        @(posedge clk_50);
        #1;
        check_val("arst_bounce_x", bounce_x, 0);
        check_val("arst_bounce_y", bounce_y, 0);
        @(negedge clk_50);
        reset_n = 1'b1;
        model_reset();
        while (n < 14) begin
            if (n == 2) begin
                check_val("relaunch_vx", ball_velocity_x, 4'h1);
                check_val("relaunch_vy", ball_velocity_y, 4'h1);
            end
            run_cycle(1'b1, 7, 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
